// File: rtl/lfsr_step_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_step_ctrl
//
// Control and feedback stage for an external NBITS-wide right-shifting shift
// register. Computes the Fibonacci feedback bit from the register state,
// drives the register's load/enable strobes, runs free-run or fixed-length
// burst sequences, offers each pre-shift state downstream over valid/ready,
// and watches for all-zero lockup and return-to-seed (period measurement).
//
// State table:
//   state  | meaning
//   LOAD   | sr_load asserted for one cycle, shift register takes seed_reg
//   IDLE   | waiting for seed_load or start
//   RUN    | stepping; one state handed downstream per step
//   DONE   | burst finished; done pulse visible for this one cycle
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   seed_load    IDLE: capture seed_in (0 is replaced by 1) and reload register
//   seed_in      seed value
//   start        IDLE: begin stepping (seed_load has priority)
//   mode         0 = free-run, 1 = burst
//   burst_len    burst step count, sampled at start
//   stop         RUN: abort to IDLE without a step or done pulse
//   q_in         current shift register state
//   sr_load      shift register synchronous load
//   sr_seed      value loaded into the shift register
//   sr_en        shift enable (one step per cycle it is high)
//   sr_shift_in  feedback bit shifted into the MSB
//   out_valid    q_in is offered downstream (RUN only)
//   out_ready    downstream accepts
//   out_data     pre-shift state, equal to q_in
//   busy         state is RUN
//   done         one-cycle pulse when a burst completes
//   step_count   steps taken since the last start
//   period       steps from start to first return to seed, 0 = not seen yet
//   wrap         one-cycle pulse after a step that returns to the seed
//   lockup       sticky all-zero error, cleared by seed_load
// ---------------------------------------------------------------------------
module lfsr_step_ctrl #(
    parameter int                NBITS = 8,
    parameter logic [NBITS-1:0]  TAPS  = 8'h1D,
    parameter int                CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [NBITS-1:0] seed_in,
    input  logic             start,
    input  logic             mode,
    input  logic [CW-1:0]    burst_len,
    input  logic             stop,
    input  logic [NBITS-1:0] q_in,
    output logic             sr_load,
    output logic [NBITS-1:0] sr_seed,
    output logic             sr_en,
    output logic             sr_shift_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    step_count,
    output logic [CW-1:0]    period,
    output logic             wrap,
    output logic             lockup
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_IDLE = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [NBITS-1:0] SEED_ONE = {{(NBITS-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [NBITS-1:0] seed_reg;
    logic [CW-1:0]    burst_reg;

    logic             run;
    logic             q_zero;
    logic             burst_empty;
    logic [NBITS-1:0] q_next;
    logic             hit_seed;
    logic [CW-1:0]    step_inc;
    logic             burst_last;

    // -----------------------------------------------------------------------
    // Datapath helpers
    // -----------------------------------------------------------------------
    assign run         = (state == S_RUN);
    assign q_zero      = (q_in == '0);
    // A zero-length burst must never step; it goes straight to DONE.
    assign burst_empty = mode && (burst_reg == '0);

    assign sr_shift_in = ^(q_in & TAPS);
    // State the shift register will hold after a step from q_in.
    assign q_next      = {sr_shift_in, q_in[NBITS-1:1]};
    assign hit_seed    = (q_next == seed_reg);

    assign step_inc    = step_count + CNT_ONE;
    assign burst_last  = mode && (step_inc == burst_reg);

    // -----------------------------------------------------------------------
    // Combinational outputs
    // -----------------------------------------------------------------------
    always_comb begin
        sr_load   = (state == S_LOAD);
        sr_seed   = seed_reg;
        busy      = run;
        out_valid = run;
        out_data  = q_in;
        sr_en     = run && out_ready && !stop && !q_zero && !burst_empty;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: state_nxt = S_IDLE;
            S_IDLE: begin
                if (seed_load) begin
                    state_nxt = S_LOAD;
                end else if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (q_zero) begin
                    state_nxt = S_IDLE;
                end else if (burst_empty) begin
                    state_nxt = S_DONE;
                end else if (sr_en && burst_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_LOAD;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_LOAD;
            seed_reg   <= SEED_ONE;
            burst_reg  <= '0;
            step_count <= '0;
            period     <= '0;
            lockup     <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state <= state_nxt;
            // DONE always exits after one cycle, so this is a single pulse.
            done  <= (state_nxt == S_DONE);
            wrap  <= sr_en && hit_seed;

            case (state)
                S_IDLE: begin
                    if (seed_load) begin
                        // An all-zero seed would lock the register immediately.
                        seed_reg <= (seed_in == '0) ? SEED_ONE : seed_in;
                        lockup   <= 1'b0;
                        period   <= '0;
                    end else if (start) begin
                        step_count <= '0;
                        period     <= '0;
                        burst_reg  <= burst_len;
                    end
                end
                S_RUN: begin
                    if (!stop && q_zero) begin
                        lockup <= 1'b1;
                    end
                    if (sr_en) begin
                        step_count <= step_inc;
                        if (hit_seed && (period == '0)) begin
                            period <= step_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
`timescale 1ns/1ps
module tb_lfsr_step_ctrl;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [7:0]  seed_in;
    logic        start;
    logic        mode;
    logic [15:0] burst_len;
    logic        stop;
    logic [7:0]  q_in;
    logic        sr_load;
    logic [7:0]  sr_seed;
    logic        sr_en;
    logic        sr_shift_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;
    logic [15:0] step_count;
    logic [15:0] period;
    logic        wrap;
    logic        lockup;

    logic [7:0]  sr_q;
    logic        force_zero;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_step_ctrl #(.NBITS(8), .TAPS(8'h1D), .CW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .start       (start),
        .mode        (mode),
        .burst_len   (burst_len),
        .stop        (stop),
        .q_in        (q_in),
        .sr_load     (sr_load),
        .sr_seed     (sr_seed),
        .sr_en       (sr_en),
        .sr_shift_in (sr_shift_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .step_count  (step_count),
        .period      (period),
        .wrap        (wrap),
        .lockup      (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 8-bit right-shifting shift register.
    always_ff @(posedge clk) begin
        if (sr_load)    sr_q <= sr_seed;
        else if (sr_en) sr_q <= {sr_shift_in, sr_q[7:1]};
    end
    assign q_in = force_zero ? 8'h00 : sr_q;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0] seq [0:5];
    int wraps;
    int hs;
    int dones;

    initial begin
        seq[0] = 8'h01; seq[1] = 8'h80; seq[2] = 8'h40;
        seq[3] = 8'h20; seq[4] = 8'h10; seq[5] = 8'h88;

        rst = 1'b0; seed_load = 1'b0; seed_in = 8'h00; start = 1'b0;
        mode = 1'b0; burst_len = 16'd0; stop = 1'b0; out_ready = 1'b0;
        force_zero = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sr_load", sr_load, 1);
        check_eq("rst_sr_seed", sr_seed, 8'h01);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_step_count", step_count, 0);
        check_eq("rst_period", period, 0);
        check_eq("rst_lockup", lockup, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wrap", wrap, 0);

        rst = 1'b1;
        #1;
        check_eq("post_rst_sr_load", sr_load, 1);
        tick();
        check_eq("load_one_cycle", sr_load, 0);
        check_eq("loaded_q", out_data, 8'h01);

        // Free-run from seed 01
        mode = 1'b0; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("fr_data_%0d", i), out_data, seq[i]);
            check_eq($sformatf("fr_count_%0d", i), step_count, i);
            if (i < 5) tick();
        end
        check_eq("fr_period_before_wrap", period, 0);

        wraps = 0;
        for (int k = 0; k < 300 && step_count != 16'd255; k++) begin
            tick();
            if (wrap) wraps++;
        end
        check_eq("wrap_count255", step_count, 255);
        check_eq("wrap_pulse", wrap, 1);
        check_eq("wrap_period", period, 255);
        check_eq("wrap_data", out_data, 8'h01);
        check_eq("wrap_once", wraps, 1);
        tick();
        check_eq("after_wrap_data", out_data, 8'h80);
        check_eq("after_wrap_pulse", wrap, 0);
        check_eq("after_wrap_period", period, 255);
        check_eq("after_wrap_count", step_count, 256);

        stop = 1'b1;
        #1;
        check_eq("stop_sr_en", sr_en, 0);
        tick();
        stop = 1'b0;
        check_eq("stop_busy", busy, 0);
        check_eq("stop_valid", out_valid, 0);
        check_eq("stop_q", out_data, 8'h80);
        check_eq("stop_done", done, 0);

        // seed_load with zero seed
        seed_in = 8'h00; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check_eq("sl0_sr_load", sr_load, 1);
        check_eq("sl0_sr_seed", sr_seed, 8'h01);
        check_eq("sl0_lockup", lockup, 0);
        check_eq("sl0_period", period, 0);
        tick();
        check_eq("sl0_q", out_data, 8'h01);
        check_eq("sl0_load_off", sr_load, 0);

        // Burst of 4
        mode = 1'b1; burst_len = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        hs = 0; dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid && out_ready) begin
                if (hs < 4) check_eq($sformatf("burst_data_%0d", hs), out_data, seq[hs]);
                hs++;
            end
            if (done) dones++;
            tick();
        end
        check_eq("burst_handshakes", hs, 4);
        check_eq("burst_done_pulses", dones, 1);
        check_eq("burst_q_after", out_data, 8'h10);
        check_eq("burst_busy_after", busy, 0);
        check_eq("burst_count", step_count, 4);

        // Zero-length burst
        burst_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("b0_busy", busy, 1);
        check_eq("b0_sr_en", sr_en, 0);
        tick();
        check_eq("b0_done", done, 1);
        check_eq("b0_busy_off", busy, 0);
        check_eq("b0_q", out_data, 8'h10);
        check_eq("b0_count", step_count, 0);
        tick();
        check_eq("b0_done_off", done, 0);

        // Stall then stop mid-burst
        burst_len = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("stall_pre_q", out_data, 8'hC4);
        check_eq("stall_pre_count", step_count, 2);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_eq($sformatf("stall_count_%0d", s), step_count, 2);
            check_eq($sformatf("stall_valid_%0d", s), out_valid, 1);
            check_eq($sformatf("stall_q_%0d", s), out_data, 8'hC4);
            check_eq($sformatf("stall_sr_en_%0d", s), sr_en, 0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("resume_count", step_count, 3);
        check_eq("resume_q", out_data, 8'hE2);
        stop = 1'b1;
        #1;
        check_eq("stop2_sr_en", sr_en, 0);
        tick();
        stop = 1'b0;
        check_eq("stop2_busy", busy, 0);
        check_eq("stop2_count", step_count, 3);
        check_eq("stop2_q", out_data, 8'hE2);
        check_eq("stop2_done", done, 0);
        tick();
        check_eq("stop2_done_late", done, 0);

        // All-zero lockup
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        force_zero = 1'b1;
        #1;
        check_eq("lock_sr_en", sr_en, 0);
        check_eq("lock_valid", out_valid, 1);
        tick();
        force_zero = 1'b0;
        check_eq("lock_set", lockup, 1);
        check_eq("lock_busy", busy, 0);
        repeat (2) tick();
        check_eq("lock_sticky", lockup, 1);
        seed_in = 8'h5A; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check_eq("lock_cleared", lockup, 0);
        check_eq("lock_seed", sr_seed, 8'h5A);
        check_eq("lock_sr_load", sr_load, 1);
        tick();
        check_eq("lock_q_reload", out_data, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
